// File: rtl/accum_add_seq.sv
// Sequential accumulator: sums a run of up to MAX_TERMS operands, one per valid/ready handshake.
// Optional macro ACCUM_SATURATE_EN clamps the sum at all-ones instead of wrapping.
module accum_add_seq #(
    parameter int WIDTH     = 5,
    parameter int MAX_TERMS = 8,
    parameter int CW        = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [CW-1:0]    num_terms,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic             stop,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] MAX_TERMS_C = CW'(MAX_TERMS);
    localparam logic [CW-1:0] ONE_C       = CW'(1);
`ifdef ACCUM_SATURATE_EN
    localparam logic [WIDTH-1:0] SUM_MAX = {WIDTH{1'b1}};
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
    logic [CW-1:0]    remaining_q, remaining_d;
    logic [WIDTH:0]   add_s;
    logic [CW-1:0]    load_cnt_s;

    function automatic logic [CW-1:0] clamp_terms(input logic [CW-1:0] n);
        logic [CW-1:0] r;
        if (n > MAX_TERMS_C) begin
            r = MAX_TERMS_C;
        end else begin
            r = n;
        end
        return r;
    endfunction

    // Next-state and datapath computation; stop outranks start and operand accept.
    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        done_d      = 1'b0;
        remaining_d = remaining_q;
        add_s       = {1'b0, sum_q} + {1'b0, A};
        load_cnt_s  = clamp_terms(num_terms);

        if (stop) begin
            state_d     = IDLE;
            sum_d       = {WIDTH{1'b0}};
            carry_d     = 1'b0;
            remaining_d = {CW{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sum_d       = {WIDTH{1'b0}};
                        carry_d     = 1'b0;
                        remaining_d = load_cnt_s;
                        if (load_cnt_s == {CW{1'b0}}) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ACCUM;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
`ifdef ACCUM_SATURATE_EN
                        if (add_s[WIDTH] || (sum_q == SUM_MAX)) begin
                            sum_d = SUM_MAX;
                        end else begin
                            sum_d = add_s[WIDTH-1:0];
                        end
`else
                        sum_d = add_s[WIDTH-1:0];
`endif
                        carry_d     = carry_q | add_s[WIDTH];
                        remaining_d = remaining_q - ONE_C;
                        if (remaining_q == ONE_C) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ACCUM;
                        end
                    end else begin
                        state_d = ACCUM;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d     = IDLE;
                    remaining_d = {CW{1'b0}};
                end
            endcase
        end
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            sum_q       <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= {CW{1'b0}};
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            done_q      <= done_d;
            remaining_q <= remaining_d;
        end
    end

    assign in_ready = (state_q == ACCUM);
    assign sum      = sum_q;
    assign carry    = carry_q;
    assign done     = done_q;

endmodule

// File: tb/tb_accum_add_seq.sv
// Self-checking bench for accum_add_seq: directed vector table, gap/clamp sequence,
// and random stimulus against a run-total reference model.
module tb_accum_add_seq;

    localparam int WIDTH     = 5;
    localparam int MAX_TERMS = 8;
    localparam int CW        = $clog2(MAX_TERMS + 1);
    localparam int SUM_MOD   = 1 << WIDTH;
`ifdef ACCUM_SATURATE_EN
    localparam logic [WIDTH-1:0] OVF_SUM = 5'd31;
`else
    localparam logic [WIDTH-1:0] OVF_SUM = 5'd3;
`endif

    logic             clk = 1'b0;
    logic             reset, start, in_valid, in_ready, stop, carry, done;
    logic [CW-1:0]    num_terms;
    logic [WIDTH-1:0] a_in, sum;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: a run is described by its true (unbounded) operand total
    bit m_active, m_done;
    int m_left, m_total;

    typedef struct {
        logic             rst;
        logic             stp;
        logic             st;
        logic [CW-1:0]    nt;
        logic             v;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] e_sum;
        logic             e_c;
        logic             e_d;
        logic             e_r;
    } vec_t;

    vec_t vecs[$];

    accum_add_seq dut (
        .clk       (clk),
        .Reset     (reset),
        .start     (start),
        .num_terms (num_terms),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a_in),
        .stop      (stop),
        .sum       (sum),
        .carry     (carry),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic st, input logic [CW-1:0] nt,
                         input logic v, input logic [WIDTH-1:0] a);
        reset     = r;
        stop      = s;
        start     = st;
        num_terms = nt;
        in_valid  = v;
        a_in      = a;
    endtask

    task automatic model_update();
        int n;
        if (reset || stop) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_left   = 0;
            m_total  = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                n       = (int'(num_terms) > MAX_TERMS) ? MAX_TERMS : int'(num_terms);
                m_total = 0;
                if (n == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_active = 1'b1;
                    m_left   = n;
                end
            end
        end else if (in_valid) begin
            m_total += int'(a_in);
            m_left--;
            if (m_left == 0) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
    endtask

    function automatic int exp_sum();
`ifdef ACCUM_SATURATE_EN
        return (m_total >= SUM_MOD) ? SUM_MOD - 1 : m_total;
`else
        return m_total % SUM_MOD;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        chk("model_sum", 32'(sum), 32'(exp_sum()));
        chk("model_carry", 32'(carry), 32'(m_total >= SUM_MOD));
        chk("model_done", 32'(done), 32'(m_done));
        chk("model_in_ready", 32'(in_ready), 32'(m_active));
    endtask

    initial begin
        int   accepts;
        bit   seen;
        logic v;

        m_active = 1'b0;
        m_done   = 1'b0;
        m_left   = 0;
        m_total  = 0;

        // rst stp st nt v a | sum carry done ready
        // basic sum 3+5+7
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 5'd3,  5'd3,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 5'd5,  5'd8,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 5'd7,  5'd15, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0,  5'd15, 1'b0, 1'b0, 1'b0});
        // overflow 20+15
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 5'd20, 5'd20, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 5'd15, OVF_SUM, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0,  OVF_SUM, 1'b1, 1'b0, 1'b0});
        // zero terms
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0});
        // abort after two accepts, operand with stop dropped, then a 1-term run
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 5'd9,  5'd9,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 5'd9,  5'd18, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 5'd9,  5'd0,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 5'd6,  5'd6,  1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0,  5'd6,  1'b0, 1'b0, 1'b0});
        // stop beats start
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0});
        // start during ACCUM ignored
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 5'd4,  5'd4,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 5'd2,  5'd6,  1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0,  5'd6,  1'b0, 1'b0, 1'b0});
        // reset mid-run
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 5'd7,  5'd7,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 5'd7,  5'd0,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0});

        // reset state
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0);
        step();
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_carry", 32'(carry), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stp, vecs[i].st, vecs[i].nt, vecs[i].v, vecs[i].a);
            step();
            chk($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].e_sum));
            chk($sformatf("vec%0d_carry", i), 32'(carry), 32'(vecs[i].e_c));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_d));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_r));
        end

        // gaps and clamp: 12 requested, 8 accepted, in_valid toggling
        drive(1'b0, 1'b0, 1'b1, 4'd12, 1'b0, 5'd0);
        step();
        accepts = 0;
        seen    = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            v = (c % 2 == 0);
            drive(1'b0, 1'b0, 1'b0, 4'd0, v, 5'd1);
            if (v && in_ready) accepts++;
            step();
            if (done) seen = 1'b1;
        end
        chk("gap_done_seen", 32'(seen), 32'd1);
        chk("gap_accepts", 32'(accepts), 32'd8);
        chk("gap_sum", 32'(sum), 32'd8);
        chk("gap_carry", 32'(carry), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0);
        step();
        chk("gap_done_one_cycle", 32'(done), 32'd0);

        // random stimulus against the model
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            step();
        end

        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
